// File: rtl/packet_rr_arbiter.sv
// Packet-aware round-robin arbiter.
// A port keeps its grant from the header flit until the packet completes by
// beat count or by a tail flit, or until it drops its request. On release
// the next requester is chosen in the same cycle, searching upward from the
// port after the one just released, so back-to-back packets have no bubble.
module packet_rr_arbiter #(
  parameter int              NUM_PORTS   = 5,
  parameter int              LEN_W       = 12,
  parameter int              FT_W        = 3,
  parameter logic [FT_W-1:0] HEADER_TYPE = 3'b001,
  parameter logic [FT_W-1:0] TAIL_TYPE   = 3'b100
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          req,
  input  logic [NUM_PORTS*FT_W-1:0]     flit_type,
  input  logic [NUM_PORTS*LEN_W-1:0]    length,
  input  logic                          out_ready,
  output logic [NUM_PORTS-1:0]          grant,
  output logic [$clog2(NUM_PORTS)-1:0]  grant_idx,
  output logic                          idle,
  output logic                          pkt_done
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  // First requester found searching upward from start, wrapping at NUM_PORTS.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_PORTS-1:0] r,
                                               input logic [IDX_W-1:0]     start);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               p;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      p = (int'(start) + k) % NUM_PORTS;
      if (!found && r[p]) begin
        pick  = IDX_W'(p);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // (i + 1) mod NUM_PORTS without relying on a power-of-two port count.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    if (int'(i) == NUM_PORTS - 1) begin
      return '0;
    end
    return i + 1'b1;
  endfunction

  // Beat counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  function automatic logic [NUM_PORTS-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NUM_PORTS-1:0] oh;
    oh    = '0;
    oh[i] = 1'b1;
    return oh;
  endfunction

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     cur_q, cur_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;

  logic [NUM_PORTS-1:0] grant_d;
  logic [IDX_W-1:0]     idx_d;
  logic                 idle_d;
  logic                 done_d;

  logic                 cur_req;
  logic [FT_W-1:0]      cur_ft;
  logic [LEN_W-1:0]     cur_len;
  logic                 xfer;
  logic                 is_hdr;
  logic                 is_tail;
  logic [LEN_W-1:0]     cnt_next;
  logic [LEN_W-1:0]     len_eff;
  logic                 complete;

  // Fields of the currently selected port and transfer/completion decode.
  always_comb begin
    cur_req  = req[cur_q];
    cur_ft   = flit_type[int'(cur_q)*FT_W +: FT_W];
    cur_len  = length[int'(cur_q)*LEN_W +: LEN_W];
    xfer     = (state_q == S_GRANT) && cur_req && out_ready;
    is_hdr   = (cur_ft == HEADER_TYPE);
    is_tail  = (cur_ft == TAIL_TYPE);
    // A header restarts the packet, even mid-packet: count 1, fresh length.
    cnt_next = is_hdr ? LEN_W'(1) : sat_inc(cnt_q);
    len_eff  = is_hdr ? cur_len : len_q;
    // Length 0 or 1 completes on the header because 1 >= len_eff.
    complete = xfer && ((cnt_next >= len_eff) || is_tail);
  end

  // Next-state, packet bookkeeping and next registered output values.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d = S_GRANT;
          cur_d   = rr_pick(req, ptr_q);
        end
      end
      S_GRANT: begin
        if (xfer) begin
          len_d = len_eff;
          cnt_d = cnt_next;
        end
        // Dropped request releases silently; completion releases with done.
        // The released port is found last in the search, so it only wins
        // again when nobody else is requesting.
        if (!cur_req || complete) begin
          ptr_d  = wrap_inc(cur_q);
          done_d = complete;
          if (|req) begin
            cur_d = rr_pick(req, wrap_inc(cur_q));
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    grant_d = (state_d == S_GRANT) ? onehot(cur_d) : '0;
    idx_d   = (state_d == S_GRANT) ? cur_d : '0;
    idle_d  = (state_d != S_GRANT);
  end

  // Arbitration state, rotating pointer and packet length/beat tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      ptr_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered outputs, all derived from the next state so they align with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant     <= '0;
      grant_idx <= '0;
      idle      <= 1'b1;
      pkt_done  <= 1'b0;
    end else begin
      grant     <= grant_d;
      grant_idx <= idx_d;
      idle      <= idle_d;
      pkt_done  <= done_d;
    end
  end

endmodule
